layer_out_collector: RTL



---
 rtl/layer_pkg.sv | 20 ++
 rtl/layer_out_collector_if.sv | 59 +++++
 rtl/argmax_tracker.sv | 52 +++++
 rtl/layer_out_collector.sv | 106 ++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer_pkg
//  Description : Shared definitions for the layer output path: default word
//                width and the collector state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package layer_pkg;

    // Default signed word width carried between layers
    localparam int LAYER_T = 16;

    // Collector states: gathering words, or holding a full vector
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_t;

endpackage
`default_nettype wire

// File: rtl/layer_out_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : layer_out_collector_if
//  Description : Word-stream input and vector output handshakes of the layer
//                output collector. The max_idx/max_val signals exist only when
//                COLLECT_ARGMAX_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface layer_out_collector_if #(
    parameter int T = 16,
    parameter int M = 4
);
    // Upstream word stream (layer is the master)
    logic                 s_valid;
    logic                 s_ready;
    logic [T-1:0]         data_in;

    // Downstream vector handshake (collector is the master)
    logic                 v_valid;
    logic                 v_ready;
    logic [M*T-1:0]       vec_out;

`ifdef COLLECT_ARGMAX_EN
    logic [$clog2(M)-1:0] max_idx;
    logic [T-1:0]         max_val;
`endif

    // Collector side
    modport slave (
        input  s_valid,
        input  data_in,
        input  v_ready,
        output s_ready,
        output v_valid,
        output vec_out
`ifdef COLLECT_ARGMAX_EN
        ,
        output max_idx,
        output max_val
`endif
    );

    // Environment side: drives words, consumes vectors
    modport master (
        output s_valid,
        output data_in,
        output v_ready,
        input  s_ready,
        input  v_valid,
        input  vec_out
`ifdef COLLECT_ARGMAX_EN
        ,
        input  max_idx,
        input  max_val
`endif
    );

endinterface
`default_nettype wire

// File: rtl/argmax_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_tracker
//  Description : Running signed maximum over the words of one vector. The
//                first word loads unconditionally; later words replace the
//                maximum only when strictly greater, so ties keep the lowest
//                index. Word indices are counted internally.
//  Revision    : 1.0  initial release
// ============================================================================
module argmax_tracker #(
    parameter int T = 16,
    parameter int M = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 load_first,
    input  wire logic                 update_en,
    input  wire logic [T-1:0]         data,
    output      logic [$clog2(M)-1:0] max_idx,
    output      logic [T-1:0]         max_val
);

    localparam int c_IDX_W = $clog2(M);

    logic [c_IDX_W-1:0] r_next;
    logic [c_IDX_W-1:0] r_max_idx;
    logic [T-1:0]       r_max_val;

    // Track index of the next word and the best word seen so far
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next    <= '0;
            r_max_idx <= '0;
            r_max_val <= {1'b1, {(T-1){1'b0}}};
        end else if (load_first) begin
            r_next    <= c_IDX_W'(1);
            r_max_idx <= '0;
            r_max_val <= data;
        end else if (update_en) begin
            r_next <= r_next + c_IDX_W'(1);
            if ($signed(data) > $signed(r_max_val)) begin
                r_max_idx <= r_next;
                r_max_val <= data;
            end
        end
    end

    assign max_idx = r_max_idx;
    assign max_val = r_max_val;

endmodule
`default_nettype wire

// File: rtl/layer_out_collector.sv
`default_nettype none
// ============================================================================
//  Module      : layer_out_collector
//  Description : Collects M signed T-bit words from a layer's serial output
//                stream into one parallel vector and hands it downstream on a
//                valid/ready handshake, back-pressuring the layer while a
//                vector is pending. Optional running argmax is enabled with
//                the COLLECT_ARGMAX_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module layer_out_collector
    import layer_pkg::*;
#(
    parameter int T = LAYER_T,
    parameter int M = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    layer_out_collector_if.slave   bus
);

    localparam int                 c_CNT_W = $clog2(M);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(M - 1);

    collect_state_t     r_state;
    logic               r_s_ready;
    logic               r_v_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic [M*T-1:0]     r_buf;

    logic               w_accept;
    logic               w_release;

    // Handshake qualifiers use only registered readies/valids
    assign w_accept  = bus.s_valid && r_s_ready;
    assign w_release = r_v_valid && bus.v_ready;

    // Collect/hold state machine with registered handshake outputs and buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= COLLECT;
            r_s_ready <= 1'b1;
            r_v_valid <= 1'b0;
            r_cnt     <= '0;
            r_buf     <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        for (int i = 0; i < M; i++) begin
                            if (r_cnt == c_CNT_W'(i)) begin
                                r_buf[i*T +: T] <= bus.data_in;
                            end
                        end
                        if (r_cnt == c_LAST) begin
                            r_cnt     <= '0;
                            r_state   <= HOLD;
                            r_s_ready <= 1'b0;
                            r_v_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (w_release) begin
                        r_state   <= COLLECT;
                        r_s_ready <= 1'b1;
                        r_v_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= COLLECT;
                    r_s_ready <= 1'b1;
                    r_v_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.v_valid = r_v_valid;
    assign bus.vec_out = r_buf;

`ifdef COLLECT_ARGMAX_EN
    logic w_first;

    // Word 0 of each vector restarts the running maximum
    assign w_first = w_accept && (r_cnt == '0);

    argmax_tracker #(
        .T (T),
        .M (M)
    ) u_argmax (
        .clk        (clk),
        .reset      (reset),
        .load_first (w_first),
        .update_en  (w_accept),
        .data       (bus.data_in),
        .max_idx    (bus.max_idx),
        .max_val    (bus.max_val)
    );
`endif

endmodule
`default_nettype wire
